ika87ad_irq_sched: RTL and testbench

Interrupt scheduler for the IKA87AD core. It sits between the per-source interrupt flag registers and the CPU microsequencer. It selects the highest-priority qualified pending flag and requests service from the CPU. On CPU acceptance it drives the auto-ack code and strobe back to the flag registers, and tells the core to clear the global interrupt enable.

---
 rtl/ika87ad_irq_sched_pkg.sv | 30 +++
 rtl/ika87ad_irq_sched_if.sv | 30 +++
 rtl/ika87ad_irq_sched_prio_enc.sv | 23 ++
 rtl/ika87ad_irq_sched.sv | 125 ++++++++++++
 tb/tb_ika87ad_irq_sched.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/ika87ad_irq_sched_pkg.sv
// Shared types and constants for the IKA87AD interrupt scheduler.
// Source indices double as the unique interrupt codes reported to the core.
package ika87ad_pkg;

   localparam int IRQ_CODE_W = 5;
   localparam int IRQ_NSRC   = 11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      ACK  = 2'd2,
      HOLD = 2'd3
   } irq_state_t;

   localparam int IRQ_NMI = 0;
   localparam int IRQ_T0  = 1;
   localparam int IRQ_T1  = 2;
   localparam int IRQ_1   = 3;
   localparam int IRQ_2   = 4;
   localparam int IRQ_E0  = 5;
   localparam int IRQ_E1  = 6;
   localparam int IRQ_EIN = 7;
   localparam int IRQ_AD  = 8;
   localparam int IRQ_SR  = 9;
   localparam int IRQ_ST  = 10;

   // E0/E1 share one vector; software tells them apart and clears them with SKIT.
   localparam logic [IRQ_NSRC-1:0] DEFAULT_MULTI_MASK = 11'b000_0110_0000;

endpackage

// File: rtl/ika87ad_irq_sched_if.sv
// Scheduler-side bundle: flag-register inputs, CPU handshake and ack strobes.
// The scheduler uses the master modport; the flag/CPU side uses slave.
interface ika87ad_irq_sched_if #(
   parameter int NSRC = 11
);
   import ika87ad_pkg::*;

   logic                  i_RSTTICK;
   logic [NSRC-1:0]       i_IFLAG;
   logic [NSRC-1:0]       i_MASK;
   logic                  i_EI;
   logic                  i_INT_ACK;
   logic                  o_INT_REQ;
   logic [IRQ_CODE_W-1:0] o_IRQ_CODE;
   logic [IRQ_CODE_W-1:0] o_ACK_CODE;
   logic                  o_AUTO_ACK;
   logic                  o_EI_CLR;
   logic                  o_BUSY;

   modport master (
      input  i_RSTTICK, i_IFLAG, i_MASK, i_EI, i_INT_ACK,
      output o_INT_REQ, o_IRQ_CODE, o_ACK_CODE, o_AUTO_ACK, o_EI_CLR, o_BUSY
   );

   modport slave (
      output i_RSTTICK, i_IFLAG, i_MASK, i_EI, i_INT_ACK,
      input  o_INT_REQ, o_IRQ_CODE, o_ACK_CODE, o_AUTO_ACK, o_EI_CLR, o_BUSY
   );

endinterface

// File: rtl/ika87ad_irq_sched_prio_enc.sv
// Fixed-priority encoder: reports whether any bit is set and the lowest set index.
// Bit 0 has the highest priority.
module ika87ad_prio_enc #(
   parameter int N     = 11,
   parameter int IDX_W = 5
) (
   input  logic [N-1:0]     vec_i,
   output logic             valid_o,
   output logic [IDX_W-1:0] idx_o
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      valid_o = |vec_i;
      idx_o   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec_i[i]) begin
            idx_o = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/ika87ad_irq_sched.sv
// Interrupt scheduler: picks the highest-priority qualified flag, requests service,
// and on acceptance drives the ack code/strobe and the global-EI clear pulse.
module ika87ad_irq_sched
   import ika87ad_pkg::*;
#(
   parameter int              NSRC       = IRQ_NSRC,
   parameter logic [NSRC-1:0] MULTI_MASK = NSRC'(DEFAULT_MULTI_MASK)
) (
   input  logic                         i_EMUCLK,
   input  logic                         i_MRST,
   ika87ad_irq_sched_if.master          bus
);

   irq_state_t            state_q,   state_d;
   logic                  req_q,     req_d;
   logic [IRQ_CODE_W-1:0] irqCode_q, irqCode_d;
   logic [IRQ_CODE_W-1:0] ackCode_q, ackCode_d;
   logic                  autoAck_q, autoAck_d;
   logic                  eiClr_q,   eiClr_d;

   logic [NSRC-1:0]       qual;
   logic                  qualValid;
   logic [IRQ_CODE_W-1:0] winner;
   logic                  winnerShared;

   // NMI bypasses both its mask bit and the global enable.
   always_comb begin
      qual    = bus.i_IFLAG & ~bus.i_MASK & {NSRC{bus.i_EI}};
      qual[0] = bus.i_IFLAG[0];
   end

   ika87ad_prio_enc #(
      .N     (NSRC),
      .IDX_W (IRQ_CODE_W)
   ) u_prio_enc (
      .vec_i   (qual),
      .valid_o (qualValid),
      .idx_o   (winner)
   );

   always_comb begin
      winnerShared = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         if (winner == IRQ_CODE_W'(i)) begin
            winnerShared = MULTI_MASK[i];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      irqCode_d = irqCode_q;
      ackCode_d = ackCode_q;
      autoAck_d = autoAck_q;
      eiClr_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (qualValid) begin
               req_d     = 1'b1;
               irqCode_d = winner;
               state_d   = PEND;
            end
         end
         PEND: begin
            if (!qualValid) begin
               req_d   = 1'b0;
               state_d = IDLE;
            end else if (bus.i_INT_ACK) begin
               req_d     = 1'b0;
               ackCode_d = winner;
               eiClr_d   = 1'b1;
               // Shared-vector sources are cleared by software, so no strobe.
               if (winnerShared) begin
                  state_d = HOLD;
               end else begin
                  autoAck_d = 1'b1;
                  state_d   = ACK;
               end
            end else begin
               irqCode_d = winner;
            end
         end
         ACK: begin
            if (bus.i_RSTTICK) begin
               autoAck_d = 1'b0;
               state_d   = HOLD;
            end
         end
         HOLD: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
      if (i_MRST) begin
         state_q   <= IDLE;
         req_q     <= 1'b0;
         irqCode_q <= '0;
         ackCode_q <= '0;
         autoAck_q <= 1'b0;
         eiClr_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         irqCode_q <= irqCode_d;
         ackCode_q <= ackCode_d;
         autoAck_q <= autoAck_d;
         eiClr_q   <= eiClr_d;
      end
   end

   assign bus.o_INT_REQ  = req_q;
   assign bus.o_IRQ_CODE = irqCode_q;
   assign bus.o_ACK_CODE = ackCode_q;
   assign bus.o_AUTO_ACK = autoAck_q;
   assign bus.o_EI_CLR   = eiClr_q;
   assign bus.o_BUSY     = (state_q != IDLE);

endmodule

// File: tb/tb_ika87ad_irq_sched.sv
// Self-checking bench for ika87ad_irq_sched: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a reference model.
module tb_ika87ad_irq_sched;
   import ika87ad_pkg::*;

   localparam int NS = 11;
   localparam logic [NS-1:0] SHARED = 11'b000_0110_0000;

   logic clk;
   logic rst;
   int   errorCount = 0;
   int   checkCount = 0;

   ika87ad_irq_sched_if #(.NSRC(NS)) bus ();

   ika87ad_irq_sched dut (
      .i_EMUCLK (clk),
      .i_MRST   (rst),
      .bus      (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: what the scheduler owes the CPU, phrased as service phases.
   int          phase;
   logic        eReq;
   int          eCode;
   int          eAck;
   logic        eAuto;
   logic        eEiClr;

   function automatic logic [NS-1:0] qualify(input logic [NS-1:0] f, input logic [NS-1:0] m,
                                             input logic ei);
      logic [NS-1:0] r;
      for (int i = 0; i < NS; i++) begin
         r[i] = (i == 0) ? f[i] : (f[i] && !m[i] && ei);
      end
      return r;
   endfunction

   function automatic int highestPriority(input logic [NS-1:0] v);
      for (int i = 0; i < NS; i++) begin
         if (v[i]) return i;
      end
      return -1;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         phase  <= 0;
         eReq   <= 1'b0;
         eCode  <= 0;
         eAck   <= 0;
         eAuto  <= 1'b0;
         eEiClr <= 1'b0;
      end else begin
         eEiClr <= 1'b0;
         case (phase)
            0: if (highestPriority(qualify(bus.i_IFLAG, bus.i_MASK, bus.i_EI)) >= 0) begin
                  eReq  <= 1'b1;
                  eCode <= highestPriority(qualify(bus.i_IFLAG, bus.i_MASK, bus.i_EI));
                  phase <= 1;
               end
            1: if (highestPriority(qualify(bus.i_IFLAG, bus.i_MASK, bus.i_EI)) < 0) begin
                  eReq  <= 1'b0;
                  phase <= 0;
               end else if (bus.i_INT_ACK) begin
                  eReq   <= 1'b0;
                  eEiClr <= 1'b1;
                  eAck   <= highestPriority(qualify(bus.i_IFLAG, bus.i_MASK, bus.i_EI));
                  if (((SHARED >> highestPriority(qualify(bus.i_IFLAG, bus.i_MASK, bus.i_EI))) & 1) != 0)
                     phase <= 3;
                  else begin
                     eAuto <= 1'b1;
                     phase <= 2;
                  end
               end else begin
                  eCode <= highestPriority(qualify(bus.i_IFLAG, bus.i_MASK, bus.i_EI));
               end
            2: if (bus.i_RSTTICK) begin
                  eAuto <= 1'b0;
                  phase <= 3;
               end
            default: phase <= 0;
         endcase
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checkCount++;
      if (actual != expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Compare the DUT against the model on every falling edge outside reset.
   always @(negedge clk) begin
      if (!rst) begin
         checkOutput("model.req",    int'(bus.o_INT_REQ),  int'(eReq));
         checkOutput("model.ack",    int'(bus.o_ACK_CODE), eAck);
         checkOutput("model.auto",   int'(bus.o_AUTO_ACK), int'(eAuto));
         checkOutput("model.eiclr",  int'(bus.o_EI_CLR),   int'(eEiClr));
         checkOutput("model.busy",   int'(bus.o_BUSY),     int'(phase != 0));
         if (eReq) checkOutput("model.code", int'(bus.o_IRQ_CODE), eCode);
      end
   end

   task automatic applyStimulus(input logic [NS-1:0] flags, input logic [NS-1:0] mask,
                                input logic ei, input logic ack, input logic tick);
      bus.i_IFLAG   = flags;
      bus.i_MASK    = mask;
      bus.i_EI      = ei;
      bus.i_INT_ACK = ack;
      bus.i_RSTTICK = tick;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst           = 1'b1;
      bus.i_IFLAG   = '0;
      bus.i_MASK    = '0;
      bus.i_EI      = 1'b0;
      bus.i_INT_ACK = 1'b0;
      bus.i_RSTTICK = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset.req",  int'(bus.o_INT_REQ),  0);
      checkOutput("reset.busy", int'(bus.o_BUSY),     0);
      checkOutput("reset.ack",  int'(bus.o_ACK_CODE), 0);
      checkOutput("reset.code", int'(bus.o_IRQ_CODE), 0);
      rst = 1'b0;

      $display("[TB] basic auto-ack of source 4");
      applyStimulus(11'h010, '0, 1'b1, 1'b0, 1'b0);
      checkOutput("t1.req",  int'(bus.o_INT_REQ),  1);
      checkOutput("t1.code", int'(bus.o_IRQ_CODE), 4);
      applyStimulus(11'h010, '0, 1'b1, 1'b1, 1'b0);
      checkOutput("t1.eiclr", int'(bus.o_EI_CLR),   1);
      checkOutput("t1.ack",   int'(bus.o_ACK_CODE), 4);
      checkOutput("t1.auto",  int'(bus.o_AUTO_ACK), 1);
      checkOutput("t1.reqlo", int'(bus.o_INT_REQ),  0);
      applyStimulus(11'h010, '0, 1'b1, 1'b0, 1'b0);
      checkOutput("t1.eiclr2", int'(bus.o_EI_CLR),   0);
      checkOutput("t1.autoh",  int'(bus.o_AUTO_ACK), 1);
      applyStimulus(11'h000, '0, 1'b1, 1'b0, 1'b1);
      checkOutput("t1.autol",  int'(bus.o_AUTO_ACK), 0);
      checkOutput("t1.hold",   int'(bus.o_BUSY),     1);
      applyStimulus(11'h000, '0, 1'b1, 1'b0, 1'b0);
      checkOutput("t1.idle",   int'(bus.o_BUSY),     0);

      $display("[TB] preemption of code 6 by code 2");
      applyStimulus(11'h040, '0, 1'b1, 1'b0, 1'b0);
      checkOutput("t2.code6", int'(bus.o_IRQ_CODE), 6);
      applyStimulus(11'h044, '0, 1'b1, 1'b0, 1'b0);
      checkOutput("t2.code2", int'(bus.o_IRQ_CODE), 2);
      applyStimulus(11'h044, '0, 1'b1, 1'b1, 1'b0);
      checkOutput("t2.ack",   int'(bus.o_ACK_CODE), 2);
      applyStimulus(11'h040, '0, 1'b1, 1'b0, 1'b1);
      applyStimulus(11'h000, '0, 1'b1, 1'b0, 1'b0);
      checkOutput("t2.idle",  int'(bus.o_BUSY), 0);

      $display("[TB] NMI served with EI low");
      applyStimulus(11'h003, '0, 1'b0, 1'b0, 1'b0);
      checkOutput("t3.req",   int'(bus.o_INT_REQ),  1);
      checkOutput("t3.code",  int'(bus.o_IRQ_CODE), 0);
      applyStimulus(11'h002, '0, 1'b0, 1'b0, 1'b0);
      checkOutput("t3.drop",  int'(bus.o_INT_REQ),  0);
      applyStimulus(11'h002, '0, 1'b1, 1'b0, 1'b0);
      checkOutput("t3.code1", int'(bus.o_IRQ_CODE), 1);
      applyStimulus(11'h000, '0, 1'b1, 1'b0, 1'b0);

      $display("[TB] shared-vector source 5");
      applyStimulus(11'h020, '0, 1'b1, 1'b0, 1'b0);
      checkOutput("t4.code",  int'(bus.o_IRQ_CODE), 5);
      applyStimulus(11'h020, '0, 1'b1, 1'b1, 1'b0);
      checkOutput("t4.eiclr", int'(bus.o_EI_CLR),   1);
      checkOutput("t4.auto",  int'(bus.o_AUTO_ACK), 0);
      checkOutput("t4.ack",   int'(bus.o_ACK_CODE), 5);
      checkOutput("t4.hold",  int'(bus.o_BUSY),     1);
      applyStimulus(11'h000, '0, 1'b1, 1'b0, 1'b0);
      checkOutput("t4.idle",  int'(bus.o_BUSY),     0);

      $display("[TB] masked while pending, stray ack ignored");
      applyStimulus(11'h008, '0, 1'b1, 1'b0, 1'b0);
      checkOutput("t5.code",  int'(bus.o_IRQ_CODE), 3);
      applyStimulus(11'h008, 11'h008, 1'b1, 1'b0, 1'b0);
      checkOutput("t5.drop",  int'(bus.o_INT_REQ),  0);
      checkOutput("t5.idle",  int'(bus.o_BUSY),     0);
      applyStimulus(11'h008, 11'h008, 1'b1, 1'b1, 1'b0);
      checkOutput("t5.eiclr", int'(bus.o_EI_CLR),   0);
      checkOutput("t5.ack",   int'(bus.o_ACK_CODE), 5);
      checkOutput("t5.busy",  int'(bus.o_BUSY),     0);

      $display("[TB] async reset during ACK");
      applyStimulus(11'h010, '0, 1'b1, 1'b0, 1'b0);
      applyStimulus(11'h010, '0, 1'b1, 1'b1, 1'b0);
      checkOutput("t6.auto", int'(bus.o_AUTO_ACK), 1);
      bus.i_INT_ACK = 1'b0;
      #2 rst = 1'b1;
      #1;
      checkOutput("t6.rauto", int'(bus.o_AUTO_ACK), 0);
      checkOutput("t6.rreq",  int'(bus.o_INT_REQ),  0);
      checkOutput("t6.rbusy", int'(bus.o_BUSY),     0);
      checkOutput("t6.rack",  int'(bus.o_ACK_CODE), 0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(11'h010, '0, 1'b1, 1'b0, 1'b0);
      checkOutput("t6.rereq", int'(bus.o_INT_REQ),  1);
      checkOutput("t6.code",  int'(bus.o_IRQ_CODE), 4);
      applyStimulus(11'h000, '0, 1'b1, 1'b0, 1'b0);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 600; n++) begin
         logic [NS-1:0] f;
         f = ($urandom_range(0, 2) == 0) ? NS'($urandom) : NS'(1 << $urandom_range(0, NS - 1));
         if ($urandom_range(0, 4) == 0) f = '0;
         applyStimulus(f, NS'($urandom) & NS'($urandom),
                       1'($urandom_range(0, 3) != 0),
                       1'($urandom_range(0, 2) == 0),
                       1'($urandom_range(0, 2) == 0));
      end

      $display("[TB] Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
